// File: rtl/el2_pkg.sv
// rtl/el2_pkg.sv - shared types for the LSU/DMA DCCM arbiter
package el2_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } arb_state_t;

    typedef enum logic {
        LSU = 1'b0,
        DMA = 1'b1
    } req_id_t;

    localparam logic [3:0] BE_FULL = 4'hF;
    localparam logic [3:0] BE_NONE = 4'h0;

endpackage

// File: rtl/el2_dccm_byte_merge.sv
// rtl/el2_dccm_byte_merge.sv - per-byte merge of new write data over an old DCCM word
module el2_dccm_byte_merge (
    input  logic [31:0] old_data,
    input  logic [31:0] new_data,
    input  logic [3:0]  be,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_data;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/rvdff.sv
// rtl/rvdff.sv - plain D flop with synchronous active-high reset
module rvdff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else begin
            dout <= din;
        end
    end

endmodule

// File: rtl/el2_lsu_dccm_arb.sv
// rtl/el2_lsu_dccm_arb.sv - LSU/DMA DCCM arbiter with DMA anti-starvation
// Partial-write read-modify-write is built only when EL2_DCCM_ARB_RMW_EN is defined.
module el2_lsu_dccm_arb
    import el2_pkg::*;
#(
    parameter int DCCM_BITS    = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 lsu_req_valid,
    output logic                 lsu_req_ready,
    input  logic                 lsu_req_wr,
    input  logic [DCCM_BITS-1:0] lsu_req_addr,
    input  logic [31:0]          lsu_req_wdata,
    input  logic [3:0]           lsu_req_be,
    output logic                 lsu_rsp_valid,
    output logic [31:0]          lsu_rsp_data,
    output logic                 lsu_rsp_err,

    input  logic                 dma_req_valid,
    output logic                 dma_req_ready,
    input  logic                 dma_req_wr,
    input  logic [DCCM_BITS-1:0] dma_req_addr,
    input  logic [31:0]          dma_req_wdata,
    input  logic [3:0]           dma_req_be,
    output logic                 dma_rsp_valid,
    output logic [31:0]          dma_rsp_data,
    output logic                 dma_rsp_err,

    output logic                 dccm_rden,
    output logic                 dccm_wren,
    output logic [DCCM_BITS-1:0] dccm_addr,
    output logic [31:0]          dccm_wr_data,
    input  logic [31:0]          dccm_rd_data
);

    localparam int            SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam int            AW         = DCCM_BITS - 2;

    arb_state_t     state;
    logic           in_idle;
    logic           dma_first;
    logic           grant_lsu;
    logic           grant_dma;
    logic           grant_any;
    logic [SW-1:0]  starve_cnt;
    logic [SW-1:0]  starve_nxt;

    req_id_t        gnt_id;
    logic           sel_wr;
    logic [AW-1:0]  sel_waddr;
    logic [31:0]    sel_wdata;
    logic [3:0]     sel_be;
    logic           sel_full;
    logic           sel_none;
    logic           sel_part;
    logic           unused_addr_lsb;

    logic           rmw_start;
    logic           rmw_cycle;

    logic           rsp_vld_d;
    req_id_t        rsp_id_d;
    logic           rsp_rd_d;
    logic           rsp_err_d;
    logic [3:0]     rsp_q;
    logic           rsp_live;
    req_id_t        rsp_id_q;

    // Arbitration: LSU has priority until DMA has lost STARVE_LIMIT times in a row
    assign in_idle   = (state == IDLE) && !rst;
    assign dma_first = dma_req_valid && (!lsu_req_valid || (starve_cnt == STARVE_MAX));
    assign grant_dma = in_idle && dma_first;
    assign grant_lsu = in_idle && lsu_req_valid && !dma_first;
    assign grant_any = grant_lsu || grant_dma;

    assign gnt_id    = grant_dma ? DMA : LSU;
    assign sel_wr    = grant_dma ? dma_req_wr    : lsu_req_wr;
    assign sel_waddr = grant_dma ? dma_req_addr[DCCM_BITS-1:2] : lsu_req_addr[DCCM_BITS-1:2];
    assign sel_wdata = grant_dma ? dma_req_wdata : lsu_req_wdata;
    assign sel_be    = grant_dma ? dma_req_be    : lsu_req_be;
    assign sel_full  = (sel_be == BE_FULL);
    assign sel_none  = (sel_be == BE_NONE);
    assign sel_part  = !sel_full && !sel_none;

    assign unused_addr_lsb = ^{lsu_req_addr[1:0], dma_req_addr[1:0]};

    always_comb begin
        starve_nxt = starve_cnt;
        if (grant_dma) begin
            starve_nxt = '0;
        end else if (dma_req_valid && (starve_cnt != STARVE_MAX)) begin
            starve_nxt = starve_cnt + SW'(1);
        end
    end

    rvdff #(.WIDTH(SW)) starve_ff (
        .clk  (clk),
        .rst  (rst),
        .din  (starve_nxt),
        .dout (starve_cnt)
    );

`ifdef EL2_DCCM_ARB_RMW_EN
    localparam int RMW_W = 1 + AW + 32 + 4;

    arb_state_t       state_nxt;
    logic             state_q;
    logic [RMW_W-1:0] rmw_d;
    logic [RMW_W-1:0] rmw_q;
    req_id_t          rmw_id;
    logic [AW-1:0]    rmw_waddr;
    logic [31:0]      rmw_wdata;
    logic [3:0]       rmw_be;
    logic [31:0]      rmw_merged;

    assign rmw_start = grant_any && sel_wr && sel_part;
    assign rmw_cycle = (state == RMW_WR) && !rst;

    rvdff #(.WIDTH(1)) state_ff (
        .clk  (clk),
        .rst  (rst),
        .din  (state_nxt),
        .dout (state_q)
    );
    assign state = arb_state_t'(state_q);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rmw_start) state_nxt = RMW_WR;
            RMW_WR:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Partial-write context held across the read half of the RMW
    assign rmw_d = rmw_start ? {gnt_id, sel_waddr, sel_wdata, sel_be} : rmw_q;

    rvdff #(.WIDTH(RMW_W)) rmw_ff (
        .clk  (clk),
        .rst  (rst),
        .din  (rmw_d),
        .dout (rmw_q)
    );

    assign rmw_id    = req_id_t'(rmw_q[RMW_W-1]);
    assign rmw_waddr = rmw_q[RMW_W-2 -: AW];
    assign rmw_wdata = rmw_q[35:4];
    assign rmw_be    = rmw_q[3:0];

    el2_dccm_byte_merge u_merge (
        .old_data (dccm_rd_data),
        .new_data (rmw_wdata),
        .be       (rmw_be),
        .merged   (rmw_merged)
    );
`else
    assign state     = IDLE;
    assign rmw_start = 1'b0;
    assign rmw_cycle = 1'b0;
`endif

    always_comb begin
        rsp_vld_d = 1'b0;
        rsp_id_d  = gnt_id;
        rsp_rd_d  = 1'b0;
        rsp_err_d = 1'b0;
        if (grant_any) begin
            if (!sel_wr) begin
                rsp_vld_d = 1'b1;
                rsp_rd_d  = 1'b1;
            end else if (sel_full || sel_none) begin
                rsp_vld_d = 1'b1;
            end else if (sel_part && !rmw_start) begin
                rsp_vld_d = 1'b1;
                rsp_err_d = 1'b1;
            end
        end
`ifdef EL2_DCCM_ARB_RMW_EN
        if (rmw_cycle) begin
            rsp_vld_d = 1'b1;
            rsp_id_d  = rmw_id;
        end
`endif
    end

    rvdff #(.WIDTH(4)) rsp_ff (
        .clk  (clk),
        .rst  (rst),
        .din  ({rsp_vld_d, rsp_id_d, rsp_rd_d, rsp_err_d}),
        .dout (rsp_q)
    );
    assign rsp_id_q = req_id_t'(rsp_q[2]);
    assign rsp_live = rsp_q[3] && !rst;

    always_comb begin
        lsu_req_ready = grant_lsu;
        dma_req_ready = grant_dma;
        dccm_rden     = 1'b0;
        dccm_wren     = 1'b0;
        dccm_addr     = '0;
        dccm_wr_data  = '0;
        if (grant_any) begin
            if (!sel_wr || rmw_start) begin
                dccm_rden = 1'b1;
                dccm_addr = {sel_waddr, 2'b00};
            end else if (sel_full) begin
                dccm_wren    = 1'b1;
                dccm_addr    = {sel_waddr, 2'b00};
                dccm_wr_data = sel_wdata;
            end
        end
`ifdef EL2_DCCM_ARB_RMW_EN
        if (rmw_cycle) begin
            dccm_wren    = 1'b1;
            dccm_addr    = {rmw_waddr, 2'b00};
            dccm_wr_data = rmw_merged;
        end
`endif
        lsu_rsp_valid = rsp_live && (rsp_id_q == LSU);
        dma_rsp_valid = rsp_live && (rsp_id_q == DMA);
        lsu_rsp_data  = (lsu_rsp_valid && rsp_q[1]) ? dccm_rd_data : 32'h0;
        dma_rsp_data  = (dma_rsp_valid && rsp_q[1]) ? dccm_rd_data : 32'h0;
        lsu_rsp_err   = lsu_rsp_valid && rsp_q[0];
        dma_rsp_err   = dma_rsp_valid && rsp_q[0];
    end

endmodule

// File: doc/el2_lsu_dccm_arb.md
EL2_LSU_DCCM_ARB -- requirements
Module: el2_lsu_dccm_arb

Interface
REQ-001 SHALL have parameter DCCM_BITS, default 16: DCCM byte-address width.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4: consecutive lost DMA arbitrations before DMA is forced to win.
REQ-003 SHALL have port clk  in  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports lsu_req_valid / dma_req_valid  in  1  request present.
REQ-006 SHALL have ports lsu_req_ready / dma_req_ready  out  1  request accepted this cycle.
REQ-007 SHALL have ports lsu_req_wr / dma_req_wr  in  1  1 = write, 0 = read.
REQ-008 SHALL have ports lsu_req_addr / dma_req_addr  in  DCCM_BITS  word-aligned; bits [1:0] ignored.
REQ-009 SHALL have ports lsu_req_wdata / dma_req_wdata  in  32  write data.
REQ-010 SHALL have ports lsu_req_be / dma_req_be  in  4  byte enables.
REQ-011 SHALL have ports lsu_rsp_valid / dma_rsp_valid  out  1  one-cycle completion pulse.
REQ-012 SHALL have ports lsu_rsp_data / dma_rsp_data  out  32  read data; 0 for writes.
REQ-013 SHALL have ports lsu_rsp_err / dma_rsp_err  out  1  request rejected.
REQ-014 SHALL have ports dccm_rden, dccm_wren  out  1, and dccm_addr  out  DCCM_BITS  (bits [1:0] driven 0).
REQ-015 SHALL have ports dccm_wr_data  out  32 and dccm_rd_data  in  32; read data is valid the cycle after dccm_rden.

Function
REQ-016 SHALL use states IDLE and RMW_WR; ready is asserted only in IDLE.
REQ-017 SHALL grant in IDLE: LSU wins when both are valid, unless starve_cnt == STARVE_LIMIT, in which case DMA wins.
REQ-018 SHALL increment starve_cnt each cycle DMA is valid and not granted, saturating at STARVE_LIMIT, and clear it on a DMA grant.
REQ-019 SHALL assert at most one of dccm_rden and dccm_wren in any cycle.
REQ-020 Read granted in cycle N: SHALL drive dccm_rden and dccm_addr in N, then rsp_valid with rsp_data = dccm_rd_data in N+1.
REQ-021 Write with be == 4'hF granted in N: SHALL drive dccm_wren, dccm_addr and dccm_wr_data in N, then rsp_valid in N+1.
REQ-022 Write with be == 0: SHALL make no DCCM access and pulse rsp_valid (err = 0) in N+1.
REQ-023 Partial write (be neither 0 nor F) granted in N: SHALL drive dccm_rden in N and move to RMW_WR, latching requester, address, wdata and be.
REQ-024 In RMW_WR (N+1): SHALL drive dccm_wren with dccm_rd_data merged per byte (be bit set selects wdata byte), pulse rsp_valid in N+2, and return to IDLE.
REQ-025 SHALL deassert both ready outputs during RMW_WR; starve_cnt still counts that cycle.
REQ-026 SHALL pulse rsp_valid only on the granted requester's response port.
REQ-027 SHALL allow a new grant in the same cycle a response is delivered, giving back-to-back throughput of 1 per cycle for non-RMW traffic.

Reset
REQ-028 While rst is high: SHALL force state IDLE, starve_cnt 0, and drive every output 0 (ready, rsp_*, dccm_*).
REQ-029 Reset asserted in RMW_WR: SHALL perform no DCCM write and deliver no response; the transaction is dropped.
REQ-030 In the first cycle after reset deasserts: SHALL arbitrate normally.

Configuration
REQ-031 Macro EL2_DCCM_ARB_RMW_EN defined: SHALL provide partial writes as in REQ-023/024.
REQ-032 Macro EL2_DCCM_ARB_RMW_EN undefined: SHALL omit the RMW_WR state and merge logic; a partial write makes no DCCM access and pulses rsp_valid with rsp_err = 1 in N+1.

Structure
REQ-033 SHALL place the state enum (IDLE, RMW_WR) and a requester-id typedef (LSU, DMA) in el2_pkg.
REQ-034 SHALL implement the byte merge as sub-module el2_dccm_byte_merge (old 32, new 32, be 4 -> merged 32); all flops SHALL be rvdff-style instances.

Verification
REQ-035 LSU read 0x0040 with dccm_rd_data = 0xDEADBEEF -> rden and addr 0x0040 in N; lsu_rsp_valid with data 0xDEADBEEF in N+1.
REQ-036 DMA write addr 0x0080, be 0x3, wdata 0x1234ABCD, old word 0xFFFFFFFF -> rden in N; wren with data 0xFFFFABCD in N+1; dma_rsp_valid in N+2.
REQ-037 Both requesters valid continuously with full-word LSU reads, STARVE_LIMIT = 4 -> LSU wins 4 cycles, DMA granted in the 5th, then the pattern repeats.
REQ-038 rst asserted in the RMW_WR cycle -> dccm_wren 0 and no rsp_valid; after release, a new LSU read completes normally.
REQ-039 Build without EL2_DCCM_ARB_RMW_EN, LSU write with be 0x1 -> no dccm_rden or dccm_wren; lsu_rsp_valid and lsu_rsp_err = 1 in N+1.
REQ-040 Write with be 0x0 -> no DCCM access; rsp_valid with err = 0 in N+1.
